// File: rtl/serdes_deser_p_if.sv
// Handshake bundle between a serial receive front-end, the deserializer and a word consumer.
// master = side that drives beats and consumes words; slave = the deserializer.
interface serdes_deser_p_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 1,
  parameter int CNT_W  = 5
) ();
  logic [LANES-1:0]  rx_data;
  logic              rx_val;
  logic              rx_rdy;
  logic              rx_clr;
  logic [DATA_W-1:0] tx_data;
  logic              tx_val;
  logic              tx_rdy;
  logic [CNT_W-1:0]  beat_cnt;

  modport master (
    output rx_data, rx_val, rx_clr, tx_rdy,
    input  rx_rdy, tx_data, tx_val, beat_cnt
  );

  modport slave (
    input  rx_data, rx_val, rx_clr, tx_rdy,
    output rx_rdy, tx_data, tx_val, beat_cnt
  );
endinterface

// File: rtl/serdes_deser_p.sv
// Serial-to-parallel deserializer: LANES bits per beat assembled into DATA_W-bit words,
// with valid/ready on both sides and a one-word output register.
module serdes_deser_p #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 5
) (
  input logic             clk,
  input logic             rst,
  serdes_deser_p_if.slave bus
);
  localparam int               BEATS    = DATA_W / LANES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_val;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_shift_next;
  logic              w_last;
  logic              w_rx_rdy;
  logic              w_accept;
  logic              w_load;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_next = {r_shift[DATA_W-LANES-1:0], bus.rx_data};
    end else begin : g_lsb_first
      assign w_shift_next = {bus.rx_data, r_shift[DATA_W-1:LANES]};
    end
  endgenerate

  // Only the completing beat can stall: it needs the output register to be free or draining.
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_rx_rdy = !(w_last && r_tx_val && !bus.tx_rdy);
  assign w_accept = bus.rx_val && w_rx_rdy && !bus.rx_clr;
  assign w_load   = w_accept && w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (bus.rx_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= w_shift_next;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // A load on the same edge as a consume replaces the word and keeps tx_val high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data <= '0;
      r_tx_val  <= 1'b0;
    end else if (w_load) begin
      r_tx_data <= w_shift_next;
      r_tx_val  <= 1'b1;
    end else if (r_tx_val && bus.tx_rdy) begin
      r_tx_val  <= 1'b0;
    end
  end

  assign bus.rx_rdy   = w_rx_rdy;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_val   = r_tx_val;
  assign bus.beat_cnt = r_cnt;
endmodule

// File: tb/tb_serdes_deser_p.sv
// Directed bench for serdes_deser_p: a 1-lane MSB-first instance and a 4-lane LSB-first instance.
module tb_serdes_deser_p;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  serdes_deser_p_if #(.DATA_W(32), .LANES(1), .CNT_W(5)) if0 ();
  serdes_deser_p_if #(.DATA_W(32), .LANES(4), .CNT_W(5)) if1 ();

  serdes_deser_p #(.DATA_W(32), .LANES(1), .MSB_FIRST(1), .CNT_W(5)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  serdes_deser_p #(.DATA_W(32), .LANES(4), .MSB_FIRST(0), .CNT_W(5)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drive one cycle on the 1-lane instance; rdy is sampled mid-cycle, state is read #1 after the edge.
  task automatic beat0(input logic v, input logic d, input logic c, output logic rdy);
    if0.rx_val  = v;
    if0.rx_data = d;
    if0.rx_clr  = c;
    @(negedge clk);
    rdy = if0.rx_rdy;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] word;
  logic [31:0] words[3];
  logic        rdy;
  int          rdy_low;
  int          n_words;
  int          pulse_at[$];

  initial begin
    rst         = 1'b0;
    if0.rx_data = '0; if0.rx_val = 1'b0; if0.rx_clr = 1'b0; if0.tx_rdy = 1'b0;
    if1.rx_data = '0; if1.rx_val = 1'b0; if1.rx_clr = 1'b0; if1.tx_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset tx_data", 64'(if0.tx_data), 64'h0);
    check("reset tx_val", 64'(if0.tx_val), 64'h0);
    check("reset beat_cnt", 64'(if0.beat_cnt), 64'h0);
    check("reset rx_rdy", 64'(if0.rx_rdy), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: one word, 1 lane, MSB first, consumer always ready
    if0.tx_rdy = 1'b1;
    word = 32'hA5A50F0F;
    rdy_low = 0;
    for (int i = 0; i < 32; i++) begin
      beat0(1'b1, word[31-i], 1'b0, rdy);
      if (!rdy) rdy_low++;
      if (i == 30) check("t1 no early tx_val", 64'(if0.tx_val), 64'h0);
    end
    check("t1 tx_val", 64'(if0.tx_val), 64'h1);
    check("t1 tx_data", 64'(if0.tx_data), 64'hA5A50F0F);
    check("t1 beat_cnt wrap", 64'(if0.beat_cnt), 64'h0);
    check("t1 rx_rdy low count", 64'(rdy_low), 64'h0);
    beat0(1'b0, 1'b0, 1'b0, rdy);
    check("t1 tx_val one cycle", 64'(if0.tx_val), 64'h0);

    // 2: 4 lanes, LSB first, nibbles 1..8
    if1.tx_rdy = 1'b1;
    check("t2 beat_cnt start", 64'(if1.beat_cnt), 64'h0);
    for (int i = 0; i < 8; i++) begin
      if1.rx_val  = 1'b1;
      if1.rx_data = 4'(i + 1);
      @(posedge clk);
      #1;
      check($sformatf("t2 beat_cnt after beat %0d", i), 64'(if1.beat_cnt), 64'((i + 1) % 8));
    end
    if1.rx_val = 1'b0;
    check("t2 tx_val", 64'(if1.tx_val), 64'h1);
    check("t2 tx_data", 64'(if1.tx_data), 64'h87654321);
    @(posedge clk);
    #1;

    // 3: backpressure, word A held while word B waits on its last beat
    if0.tx_rdy = 1'b0;
    word = 32'h12345678;
    for (int i = 0; i < 32; i++) beat0(1'b1, word[31-i], 1'b0, rdy);
    check("t3 A tx_val", 64'(if0.tx_val), 64'h1);
    check("t3 A tx_data", 64'(if0.tx_data), 64'h12345678);
    word = 32'hDEADBEEF;
    rdy_low = 0;
    for (int i = 0; i < 31; i++) begin
      beat0(1'b1, word[31-i], 1'b0, rdy);
      if (!rdy) rdy_low++;
    end
    check("t3 B partial beats never stalled", 64'(rdy_low), 64'h0);
    check("t3 beat_cnt at last", 64'(if0.beat_cnt), 64'd31);
    for (int k = 0; k < 3; k++) begin
      beat0(1'b1, word[0], 1'b0, rdy);
      check("t3 rx_rdy stalled", 64'(rdy), 64'h0);
      check("t3 A held", 64'(if0.tx_data), 64'h12345678);
    end
    check("t3 beat_cnt held", 64'(if0.beat_cnt), 64'd31);
    if0.tx_rdy = 1'b1;
    beat0(1'b1, word[0], 1'b0, rdy);
    check("t3 rx_rdy with tx_rdy", 64'(rdy), 64'h1);
    check("t3 B tx_data", 64'(if0.tx_data), 64'hDEADBEEF);
    check("t3 B tx_val", 64'(if0.tx_val), 64'h1);
    check("t3 beat_cnt after B", 64'(if0.beat_cnt), 64'h0);
    if0.tx_rdy = 1'b0;
    beat0(1'b0, 1'b0, 1'b0, rdy);
    check("t3 B still held", 64'(if0.tx_data), 64'hDEADBEEF);
    if0.tx_rdy = 1'b1;
    beat0(1'b0, 1'b0, 1'b0, rdy);
    check("t3 drained", 64'(if0.tx_val), 64'h0);

    // 4: random partial word, rx_clr with a simultaneous beat, then all ones
    for (int i = 0; i < 10; i++) beat0(1'b1, 1'($urandom_range(1)), 1'b0, rdy);
    check("t4 beat_cnt before clr", 64'(if0.beat_cnt), 64'd10);
    beat0(1'b1, 1'b1, 1'b1, rdy);
    check("t4 beat_cnt after clr", 64'(if0.beat_cnt), 64'h0);
    n_words = 0;
    for (int i = 0; i < 32; i++) begin
      beat0(1'b1, 1'b1, 1'b0, rdy);
      if (if0.tx_val) n_words++;
    end
    check("t4 tx_data", 64'(if0.tx_data), 64'hFFFFFFFF);
    check("t4 words out", 64'(n_words), 64'h1);
    beat0(1'b0, 1'b0, 1'b0, rdy);

    // 5: asynchronous reset mid-word while a word is held
    if0.tx_rdy = 1'b0;
    word = 32'h0F0F0F0F;
    for (int i = 0; i < 32; i++) beat0(1'b1, word[31-i], 1'b0, rdy);
    for (int i = 0; i < 17; i++) beat0(1'b1, 1'b1, 1'b0, rdy);
    check("t5 tx_val before rst", 64'(if0.tx_val), 64'h1);
    check("t5 beat_cnt before rst", 64'(if0.beat_cnt), 64'd17);
    if0.rx_val = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("t5 async tx_data", 64'(if0.tx_data), 64'h0);
    check("t5 async tx_val", 64'(if0.tx_val), 64'h0);
    check("t5 async beat_cnt", 64'(if0.beat_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    if0.tx_rdy = 1'b1;
    word = 32'h0000FFFF;
    n_words = 0;
    for (int i = 0; i < 32; i++) begin
      beat0(1'b1, word[31-i], 1'b0, rdy);
      if (if0.tx_val) n_words++;
    end
    check("t5 tx_data", 64'(if0.tx_data), 64'h0000FFFF);
    check("t5 words out", 64'(n_words), 64'h1);

    // 6: 96 continuous beats, full throughput
    words[0] = 32'h01234567;
    words[1] = 32'h89ABCDEF;
    words[2] = 32'hCAFEF00D;
    rdy_low = 0;
    for (int j = 0; j < 96; j++) begin
      word = words[j / 32];
      beat0(1'b1, word[31 - (j % 32)], 1'b0, rdy);
      if (!rdy) rdy_low++;
      if (if0.tx_val) begin
        pulse_at.push_back(j);
        check($sformatf("t6 word at beat %0d", j), 64'(if0.tx_data), 64'(words[(j / 32) % 3]));
      end
    end
    beat0(1'b0, 1'b0, 1'b0, rdy);
    check("t6 rx_rdy never low", 64'(rdy_low), 64'h0);
    check("t6 pulse count", 64'(pulse_at.size()), 64'd3);
    if (pulse_at.size() == 3) begin
      check("t6 first pulse", 64'(pulse_at[0]), 64'd31);
      check("t6 spacing 1", 64'(pulse_at[1] - pulse_at[0]), 64'd32);
      check("t6 spacing 2", 64'(pulse_at[2] - pulse_at[1]), 64'd32);
    end
    check("t6 tx_val after drain", 64'(if0.tx_val), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serdes_deser_p.md
Name: serdes_deser_p

Overview:
Parametrised serial-to-parallel deserializer, the next generation of the team's 1-bit-to-32-bit serdes.
- Accepts LANES bits per beat and assembles DATA_W-bit words, with selectable bit order.
- Valid/ready handshake on both the input and output sides, so a full word is never lost under backpressure.
- Sits between a serial receive front-end and a word-wide consumer (FIFO or bus bridge).

Parameters:
DATA_W, 32, output word width; must be a multiple of LANES.
LANES, 1, bits per input beat; must be 1, 2, 4, 8 or 16.
MSB_FIRST, 1, 1 = first beat lands in the most significant bits; 0 = first beat lands in the least significant bits.
CNT_W, 5, beat-counter width; must be at least clog2(DATA_W/LANES); default covers 32 beats.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous active-low reset.
rx_data  input  LANES  serial beat data.
rx_val  input  1  rx_data is valid this cycle.
rx_rdy  output  1  block can accept a beat this cycle (combinational).
rx_clr  input  1  synchronous discard of the partially assembled word.
tx_data  output  DATA_W  assembled word (registered).
tx_val  output  1  tx_data holds an unconsumed word (registered).
tx_rdy  input  1  consumer takes the word this cycle.
beat_cnt  output  CNT_W  beats accumulated in the current partial word (registered).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-low.
- Reset state (asserted at any time, including mid-word): tx_data=0, tx_val=0, beat_cnt=0, shift register=0. The partial word is lost. rx_rdy evaluates to 1 after reset.
- BEATS = DATA_W/LANES.
- Beat acceptance:
  - A beat is accepted when rx_val && rx_rdy.
  - Beats with rx_val=0 do not advance state. Gaps between beats are allowed at any point.
- Assembly:
  - MSB_FIRST=1: shift register shifts left by LANES; new beat enters bits [LANES-1:0].
  - MSB_FIRST=0: shift register shifts right by LANES; new beat enters the top LANES bits.
  - beat_cnt increments per accepted beat and wraps from BEATS-1 to 0 on the completing beat.
- Completion:
  - On the accepted beat with beat_cnt==BEATS-1, the full word (including this beat) is loaded into tx_data at the same edge.
  - tx_val=1 from the next cycle. Latency is 1 cycle from the last beat to tx_val.
  - The shift register is not required to clear; it is fully overwritten by the next word.
- Output handshake:
  - The word is consumed when tx_val && tx_rdy; tx_val falls the next cycle unless a new word loads on the same edge.
  - tx_data is stable while tx_val && !tx_rdy.
- Backpressure:
  - rx_rdy = !(beat_cnt==BEATS-1 && tx_val && !tx_rdy).
  - Partial beats are always accepted; only the completing beat stalls when the output register is occupied and not draining.
  - Load and consume in the same cycle is legal: the new word replaces the old one and tx_val stays 1. This gives full throughput of one word per BEATS cycles.
- rx_clr:
  - Sets beat_cnt=0 and the shift register to 0 at the next edge.
  - Has priority over a simultaneous beat; that beat is dropped even if rx_val && rx_rdy.
  - Does not affect tx_data or tx_val.
  - With rx_clr and completion in the same cycle, rx_clr wins and no word is loaded.
- No combinational path from rx_data to tx_data. rx_rdy depends combinationally on tx_rdy only.

Test Plan:
1. DATA_W=32, LANES=1, MSB_FIRST=1, tx_rdy=1; feed the bits of 0xA5A50F0F MSB first on 32 consecutive cycles -> tx_data=0xA5A50F0F and tx_val=1 in the cycle after the 32nd beat, for one cycle; rx_rdy stays 1 throughout.
2. LANES=4, MSB_FIRST=0; feed nibbles 1,2,3,4,5,6,7,8 -> tx_data=0x87654321; beat_cnt steps 0..7 and then returns to 0.
3. LANES=1, tx_rdy=0; stream 64 beats of word A=0x12345678 then word B=0xDEADBEEF -> A is held with tx_val=1; rx_rdy=0 while B's 32nd beat is presented; pulse tx_rdy for one cycle -> B's last beat is accepted that cycle and tx_data=0xDEADBEEF the next cycle; no beat is lost or duplicated.
4. 10 random beats, then rx_clr=1 together with rx_val=1, then 32 beats of 1 -> only 0xFFFFFFFF is output; beat_cnt=0 after rx_clr.
5. Assert rst mid-word after 17 beats while tx_val=1 -> tx_data=0, tx_val=0 and beat_cnt=0 immediately, asynchronously; the next 32 beats of 0x0000FFFF produce exactly 0x0000FFFF.
6. tx_rdy=1 with 96 continuous beats -> three words with tx_val pulses exactly 32 cycles apart and rx_rdy never deasserted.
